// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage and IF/ID register.
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int unsigned DROP_TIMEOUT = 16;
    localparam int unsigned DROP_CNT_W   = $clog2(DROP_TIMEOUT);

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset/flush bubble, stall hold, then hold buffer
// ahead of a live memory response, otherwise a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            hold_valid,
    input  logic [31:0]     hold_instr,
    input  logic [XLEN-1:0] hold_pc,
    input  logic            rsp_live,
    input  logic [31:0]     rsp_instr,
    input  logic [XLEN-1:0] rsp_pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);

    logic            src_valid;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;

    // The hold buffer is older than any live response, so it goes first.
    always_comb begin
        src_valid = hold_valid || rsp_live;
        src_instr = rsp_instr;
        src_pc    = rsp_pc;
        if (hold_valid) begin
            src_instr = hold_instr;
            src_pc    = hold_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (!stall) begin
            if (src_valid) begin
                instr    <= src_instr;
                pc       <= src_pc;
                pc_plus4 <= src_pc + XLEN'(4);
                valid    <= 1'b1;
            end else begin
                instr    <= NOP_INSTR;
                pc       <= '0;
                pc_plus4 <= '0;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, single-outstanding imem request FSM, stale-response drop and
// one-entry hold buffer. FETCH_PERF_EN adds bubble/drop performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pcsrcE,
    input  logic [XLEN-1:0] pcTargetE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perfBubbleCnt,
    output logic [31:0]     perfDropCnt,
`endif
    output logic            validD
);

    fetch_state_t          state, state_next;
    logic [XLEN-1:0]       pc_f, pc_next, req_pc, hold_pc;
    logic [31:0]           hold_instr;
    logic                  hold_valid, hold_load;
    logic                  handshake, rsp_eff, rsp_live;
    logic                  drop_pending;
    logic [DROP_CNT_W-1:0] drop_cnt;

    always_comb begin
        imem_req_valid = (state == ISSUE) && !stallF && !hold_valid && !rst;
        imem_req_addr  = pc_f;
        handshake      = imem_req_valid && imem_req_ready;
        // A response owed to a pre-reset request is invisible to the FSM.
        rsp_eff        = imem_rsp_valid && !drop_pending;
        state_next     = state;
        rsp_live       = 1'b0;
        case (state)
            ISSUE: begin
                if (handshake) state_next = pcsrcE ? DROP : WAIT;
            end
            WAIT: begin
                if (rsp_eff) begin
                    state_next = ISSUE;
                    rsp_live   = !pcsrcE;
                end else if (pcsrcE) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (rsp_eff) state_next = ISSUE;
            end
            default: state_next = ISSUE;
        endcase
        pc_next   = pcsrcE ? pcTargetE : (handshake ? pc_f + XLEN'(4) : pc_f);
        hold_load = rsp_live && !flushD && (stallD || hold_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ISSUE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f   <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            pc_f <= pc_next;
            if (handshake) req_pc <= pc_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
        end else if (hold_load) begin
            hold_valid <= 1'b1;
            hold_instr <= imem_rsp_data;
            hold_pc    <= req_pc;
        end else if (hold_valid && !stallD) begin
            hold_valid <= 1'b0;
        end
    end

    // Armed only when reset cuts off a request whose response is still owed.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            if (imem_rsp_valid)      drop_pending <= 1'b0;
            else if (state != ISSUE) drop_pending <= 1'b1;
        end else if (drop_pending) begin
            if (imem_rsp_valid || drop_cnt == DROP_CNT_W'(DROP_TIMEOUT - 1)) begin
                drop_pending <= 1'b0;
            end else begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (flushD),
        .stall      (stallD),
        .hold_valid (hold_valid),
        .hold_instr (hold_instr),
        .hold_pc    (hold_pc),
        .rsp_live   (rsp_live),
        .rsp_instr  (imem_rsp_data),
        .rsp_pc     (req_pc),
        .instr      (instrD),
        .pc         (pcD),
        .pc_plus4   (pcPlus4D),
        .valid      (validD)
    );

`ifdef FETCH_PERF_EN
    logic drop_evt, bubble_evt;

    always_comb begin
        drop_evt   = imem_rsp_valid &&
                     (drop_pending || state == DROP || (state == WAIT && pcsrcE));
        bubble_evt = !stallD && (flushD || !(hold_valid || rsp_live));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perfBubbleCnt <= '0;
            perfDropCnt   <= '0;
        end else begin
            if (bubble_evt) perfBubbleCnt <= perfBubbleCnt + 32'd1;
            if (drop_evt)   perfDropCnt   <= perfDropCnt + 32'd1;
        end
    end
`endif

endmodule
